// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: opcodes, control-phase encoding and opcode classification.
package mu0_pkg;

    localparam int unsigned IR_W   = 16;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned ADDR_W = 12;

    localparam logic [OPC_W-1:0] OPC_LDA = 4'h0;
    localparam logic [OPC_W-1:0] OPC_STA = 4'h1;
    localparam logic [OPC_W-1:0] OPC_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OPC_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OPC_JMP = 4'h4;
    localparam logic [OPC_W-1:0] OPC_JGE = 4'h5;
    localparam logic [OPC_W-1:0] OPC_JNE = 4'h6;
    localparam logic [OPC_W-1:0] OPC_STP = 4'h7;
    localparam logic [OPC_W-1:0] OPC_AND = 4'h8;
    localparam logic [OPC_W-1:0] OPC_LSL = 4'h9;
    localparam logic [OPC_W-1:0] OPC_LSR = 4'hA;

    // One-hot so every phase strobe is a flop output.
    localparam int unsigned PH_W = 5;
    typedef enum logic [PH_W-1:0] {
        PH_IDLE  = 5'b00001,
        PH_FETCH = 5'b00010,
        PH_EXEC1 = 5'b00100,
        PH_EXEC2 = 5'b01000,
        PH_HALT  = 5'b10000
    } phase_e;

    localparam int unsigned PH_FETCH_BIT = 1;
    localparam int unsigned PH_EXEC1_BIT = 2;
    localparam int unsigned PH_EXEC2_BIT = 3;
    localparam int unsigned PH_HALT_BIT  = 4;

    function automatic logic is_two_phase(input logic [OPC_W-1:0] op);
        return (op == OPC_LDA) || (op == OPC_ADD) || (op == OPC_SUB);
    endfunction

endpackage

// File: rtl/mu0_phase_sequencer_step_edge_detect.sv
// Registered rising-edge detector for the single-step request.
module step_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic step_i,
    output logic rise_c
);

    logic step_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_i;
        end
    end

    assign rise_c = step_i & ~step_q;

endmodule

// File: rtl/mu0_phase_sequencer.sv
// MU0 control-phase sequencer: owns the IR, drives FETCH/EXEC1/EXEC2 strobes to the decoder,
// supports free-run and single-step, halts on STP and counts active cycles.
module mu0_phase_sequencer
    import mu0_pkg::*;
#(
    parameter int unsigned        CNT_W    = 16,
    parameter logic [IR_W-1:0]    IR_RESET = 16'h0000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RUN,
    input  logic              STEP,
    input  logic [IR_W-1:0]   MEM_Q,
    output logic              FETCH,
    output logic              EXEC1,
    output logic              EXEC2,
    output logic [OPC_W-1:0]  OP,
    output logic [ADDR_W-1:0] ADDR_FIELD,
    output logic              IR_LOAD,
    output logic              INSTR_DONE,
    output logic              HALTED,
    output logic [CNT_W-1:0]  CYCLE_CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    phase_e           state_q, state_d;
    logic [IR_W-1:0]  ir_q, ir_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_rise_c;
    logic             active_c;

    step_edge_detect u_step_edge (
        .clk    (CLK),
        .rst    (RESET),
        .step_i (STEP),
        .rise_c (step_rise_c)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= PH_IDLE;
            ir_q    <= IR_RESET;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign active_c = state_q[PH_FETCH_BIT] | state_q[PH_EXEC1_BIT] | state_q[PH_EXEC2_BIT];

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            PH_IDLE: begin
                if (RUN || step_rise_c) begin
                    state_d = PH_FETCH;
                end
            end
            PH_FETCH: begin
                ir_d    = MEM_Q;
                state_d = PH_EXEC1;
            end
            PH_EXEC1: begin
                if (is_two_phase(ir_q[IR_W-1 -: OPC_W])) begin
                    state_d = PH_EXEC2;
                end else if (ir_q[IR_W-1 -: OPC_W] == OPC_STP) begin
                    state_d = PH_HALT;
                end else begin
                    state_d = RUN ? PH_FETCH : PH_IDLE;
                end
            end
            PH_EXEC2: begin
                state_d = RUN ? PH_FETCH : PH_IDLE;
            end
            PH_HALT: begin
                state_d = PH_HALT;
            end
            default: begin
                state_d = PH_IDLE;
            end
        endcase

        // INSTR_DONE is registered, so it is decided from the phase being entered.
        done_d = (state_d == PH_EXEC2) ||
                 ((state_d == PH_EXEC1) && !is_two_phase(ir_d[IR_W-1 -: OPC_W]));

        if (active_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign FETCH      = state_q[PH_FETCH_BIT];
    assign EXEC1      = state_q[PH_EXEC1_BIT];
    assign EXEC2      = state_q[PH_EXEC2_BIT];
    assign HALTED     = state_q[PH_HALT_BIT];
    assign IR_LOAD    = state_q[PH_FETCH_BIT];
    assign INSTR_DONE = done_q;
    assign OP         = ir_q[IR_W-1 -: OPC_W];
    assign ADDR_FIELD = ir_q[ADDR_W-1:0];
    assign CYCLE_CNT  = cnt_q;

endmodule

// File: tb/tb_mu0_phase_sequencer.sv
// Randomized self-checking bench for mu0_phase_sequencer against an instruction-level model.
module tb_mu0_phase_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        RUN;
    logic        STEP;
    logic [15:0] MEM_Q;

    logic        FETCH, EXEC1, EXEC2, IR_LOAD, INSTR_DONE, HALTED;
    logic [3:0]  OP;
    logic [11:0] ADDR_FIELD;
    logic [15:0] CYCLE_CNT;

    logic        s_fetch, s_exec1, s_exec2, s_ir_load, s_done, s_halted;
    logic [3:0]  s_op;
    logic [11:0] s_addr;
    logic [2:0]  s_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Instruction-level model: position within the current instruction and its length.
    bit          m_active, m_halt, m_step_prev;
    int          m_k, m_len, m_cnt;
    logic [15:0] m_ir;

    always #5 CLK = ~CLK;

    mu0_phase_sequencer #(.CNT_W(16), .IR_RESET(16'h0000)) dut (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP), .MEM_Q(MEM_Q),
        .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .OP(OP), .ADDR_FIELD(ADDR_FIELD),
        .IR_LOAD(IR_LOAD), .INSTR_DONE(INSTR_DONE), .HALTED(HALTED), .CYCLE_CNT(CYCLE_CNT)
    );

    mu0_phase_sequencer #(.CNT_W(3), .IR_RESET(16'h0000)) dut_small (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP), .MEM_Q(MEM_Q),
        .FETCH(s_fetch), .EXEC1(s_exec1), .EXEC2(s_exec2), .OP(s_op), .ADDR_FIELD(s_addr),
        .IR_LOAD(s_ir_load), .INSTR_DONE(s_done), .HALTED(s_halted), .CYCLE_CNT(s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_active = 0; m_halt = 0; m_step_prev = 0;
        m_k = 0; m_len = 0; m_cnt = 0; m_ir = 16'h0000;
    endtask

    // One clock edge of the model, driven by the inputs present at that edge.
    task automatic model_edge();
        bit rise;
        int op;
        rise = STEP && !m_step_prev;
        m_step_prev = STEP;
        if (m_halt) return;
        if (!m_active) begin
            if (RUN || rise) begin
                m_active = 1; m_k = 0;
            end
            return;
        end
        m_cnt++;
        if (m_k == 0) begin
            m_ir  = MEM_Q;
            op    = int'(MEM_Q[15:12]);
            m_len = (op == 0 || op == 2 || op == 3) ? 3 : 2;
            m_k   = 1;
        end else if (m_k < m_len - 1) begin
            m_k++;
        end else if (m_ir[15:12] == 4'h7) begin
            m_halt = 1; m_active = 0;
        end else if (RUN) begin
            m_k = 0;
        end else begin
            m_active = 0;
        end
    endtask

    task automatic check_all();
        logic [5:0] exp_ph, obs_ph, obs_s;
        bit f, e1, e2, dn;
        f  = m_active && m_k == 0;
        e1 = m_active && m_k == 1;
        e2 = m_active && m_k == 2;
        dn = m_active && m_k > 0 && m_k == m_len - 1;
        exp_ph = {f, e1, e2, f, dn, m_halt};
        obs_ph = {FETCH, EXEC1, EXEC2, IR_LOAD, INSTR_DONE, HALTED};
        obs_s  = {s_fetch, s_exec1, s_exec2, s_ir_load, s_done, s_halted};
        check("phase", 32'(obs_ph), 32'(exp_ph));
        check("phase_small", 32'(obs_s), 32'(exp_ph));
        check("op", 32'(OP), 32'(m_ir[15:12]));
        check("addr", 32'(ADDR_FIELD), 32'(m_ir[11:0]));
        check("cnt16", 32'(CYCLE_CNT), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
        check("cnt3", 32'(s_cnt), (m_cnt > 7) ? 32'd7 : 32'(m_cnt));
        check("onehot", 32'($countones({FETCH, EXEC1, EXEC2}) <= 1), 32'd1);
    endtask

    // Inputs are set in the low phase; outputs are checked at the following negedge.
    task automatic cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    // Reset asserted mid low-phase; outputs must clear before the next rising edge.
    task automatic apply_reset();
        #2 RESET = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bit found;
        RESET = 1'b1; RUN = 1'b0; STEP = 1'b0; MEM_Q = 16'h0000;
        model_reset();
        @(negedge CLK);
        check_all();
        RESET = 1'b0;

        // Free-running JMP, then RUN drops and the sequencer settles in IDLE
        RUN = 1'b1; MEM_Q = 16'h4005;
        run_cycles(5);
        RUN = 1'b0;
        run_cycles(3);

        // Free-running ADD, three cycles per instruction
        RUN = 1'b1; MEM_Q = 16'h2010;
        run_cycles(7);
        RUN = 1'b0;
        run_cycles(4);

        // Single-step: one pulse, held STEP, and an edge during EXEC1
        MEM_Q = 16'h0003;
        STEP = 1'b1; cycle(); STEP = 1'b0; run_cycles(4);
        STEP = 1'b1; run_cycles(5); STEP = 1'b0; run_cycles(2);
        STEP = 1'b1; cycle(); STEP = 1'b0; cycle(); STEP = 1'b1; cycle();
        STEP = 1'b0; run_cycles(3);

        // Async reset during EXEC1 of ADD, then restart with RUN
        RUN = 1'b1; MEM_Q = 16'h2010;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            found = m_active && m_k == 1;
        end
        check("reach_exec1", 32'(found), 32'd1);
        apply_reset();
        run_cycles(3);

        // STP halts; RUN/STEP activity is ignored until reset
        MEM_Q = 16'h7000;
        run_cycles(3);
        for (int i = 0; i < 8; i++) begin
            RUN = 1'(i & 1); STEP = 1'((i >> 1) & 1);
            cycle();
        end
        apply_reset();

        // Counter saturation on the narrow instance, and an undefined opcode as NOP
        RUN = 1'b1; STEP = 1'b0; MEM_Q = 16'h1000;
        run_cycles(12);
        MEM_Q = 16'hC000;
        run_cycles(6);
        apply_reset();

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            RUN   = ($urandom_range(3) != 0);
            STEP  = 1'($urandom_range(1));
            MEM_Q = {4'($urandom_range(15)), 12'($urandom)};
            if ((m_halt && $urandom_range(5) == 0) || $urandom_range(99) == 0) apply_reset();
            else cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
